// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: a, b, op -> result/zero/err; no latency, no flow control.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR: result = ~(a | b);
      default: err = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; result registered (1 cycle).
// Grants only when the output slot is empty or draining; a stalled consumer holds both readys low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  logic             last_grant;
  logic             slot_free;
  logic             pick1;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_err;

  assign slot_free = !rsp_valid || rsp_ready;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1  = req1_valid && (!req0_valid || !last_grant);
  assign grant0 = !reset && slot_free && req0_valid && !pick1;
  assign grant1 = !reset && slot_free && pick1;
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a  = pick1 ? req1_a  : req0_a;
  assign alu_b  = pick1 ? req1_b  : req0_b;
  assign alu_op = pick1 ? req1_op : req0_op;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_err    <= alu_err;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU between two requesters (the EX-stage operand path and the branch-compare unit) in the single-cycle/pipelined core. Each requester presents operands and a 4-bit ALU control code on a valid/ready handshake; the block grants one request per cycle with round-robin fairness. It computes the result through an embedded ALU core and holds it in a one-entry output register until the consumer accepts it.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH each  requester 0 operands
- req0_op  in  4  requester 0 ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer accepts the result this cycle
- rsp_id  out  1  index of the requester that produced rsp_result
- rsp_result  out  WIDTH  ALU result
- rsp_zero  out  1  high when rsp_result == 0
- rsp_err  out  1  high when the op code was unsupported

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^WIDTH)
  - 0110 SUB (wraps)
  - 0111 SLT: signed two's-complement compare; result 1 if a < b, else 0, zero-extended
  - 1100 NOR: ~(a | b)
  - Any other code: result 0, rsp_zero 1, rsp_err 1.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant:
  - Only when slot_free.
  - One valid requester: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - reqN_ready = grant to N (combinational from valid, slot_free, last_grant).
  - reqN_ready never asserts while reqN_valid is low.
- On a grant at a clock edge:
  - The output register loads result, zero, err and id of the granted requester.
  - rsp_valid is set.
  - last_grant is updated to the granted index.
- Drain without a new grant: rsp_valid clears.
- Drain with a new grant in the same cycle (simultaneous drain and grant): the register reloads, rsp_valid stays 1, and no bubble is inserted.
- Stall: while rsp_valid=1 and rsp_ready=0, all output fields hold stable and both readys are 0.
- Requesters may drop valid or change operands freely while not granted. The block keeps no state per requester.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, last_grant 1 (so requester 0 wins the first tie).
- Latency: the result appears on rsp_* in the cycle after the handshake (1 cycle).
- Throughput: one operation per cycle when rsp_ready is held at 1.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A requester waits at most one grant behind the other.
- Reset asserted mid-operation: the held result is discarded, outputs go to their reset values asynchronously, and readys are 0 while reset is high.
- No combinational path from rsp_ready to rsp_* data. Paths rsp_ready → reqN_ready and reqN_valid → reqN_ready are allowed.

## Structure
- Shared package alu_pkg:
  - 4-bit op-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR)
  - WIDTH default
- Sub-module alu_core: purely combinational (a, b, op → result, zero, err), instantiated once.
- Arbiter and output register live in alu_arbiter.

## Test plan
- Single request: reset, then req0 ADD a=5 b=7. Expect req0_ready=1 that cycle. Next cycle: rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0.
- Contention: both requesters valid for 4 cycles with rsp_ready=1, req0 SUB 3−3 and req1 SLT a=0xFFFFFFFF b=1. Expect grants 0,1,0,1. Results alternate 0 (zero=1) and 1 (zero=0).
- Back-pressure: result pending with rsp_ready=0 for 3 cycles while req1 is valid. Expect outputs stable and req1_ready=0. Raise rsp_ready: req1 is granted the same cycle and the new result follows next cycle with no bubble.
- Ops and error: NOR a=0 b=0 gives 0xFFFFFFFF. ADD 0xFFFFFFFF+1 gives 0 with zero=1. op=0101 gives result 0, rsp_err=1.
- Reset mid-operation: assert reset while rsp_valid=1 and rsp_ready=0. Expect rsp_valid=0 immediately. After release with both requesters valid, requester 0 wins first.
